ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
Instruction fetch unit directly upstream of iccm_controller. Generates sequential PCs and issues word reads on the controller read port (cntlr_rd/cntlr_raddr). It consumes cntlr_rd_data/cntlr_rd_valid into a small prefetch FIFO that feeds decode over a valid/ready handshake. Branch redirects flush the FIFO and squash in-flight responses.

Parameters:
ADDR_WIDTH, 11, ICCM word-address width; matches iccm_controller/sram_8kb.
DATA_WIDTH, 32, instruction width.
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
MAX_OUT, 2, maximum in-flight controller reads, counting both live and squashed.
RESET_PC, 32'h0000_0000, byte PC loaded at reset.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allow new requests; gating only, no flush
redirect_valid  in  1  one-cycle branch/trap redirect
redirect_pc  in  32  redirect target byte address
cntlr_rd  out  1  read request, one word per high cycle
cntlr_raddr  out  ADDR_WIDTH  word address = pc[ADDR_WIDTH+1:2]
cntlr_rd_data  in  DATA_WIDTH  read data
cntlr_rd_valid  in  1  response strobe; in order, one per request, at least 1 cycle after the request
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr_data  out  DATA_WIDTH  head instruction
instr_pc  out  32  head byte PC
fetch_misalign  out  1  sticky misaligned-redirect flag (see Optional Feature)
busy  out  1  outstanding != 0 or squash_cnt != 0

Interface decisions:
- One clock, clk.
- Reset rst_n, asynchronous, active-low.

Behaviour:
- Reset state:
  - req_pc = resp_pc = RESET_PC.
  - FIFO empty; outstanding = squash_cnt = 0; state IDLE.
  - All outputs 0, except cntlr_raddr = RESET_PC[ADDR_WIDTH+1:2].
  - Reset mid-transaction drops all in-flight state; late strobes after reset are a controller violation.
- States:
  - IDLE to FETCH when fetch_en = 1.
  - FETCH to IDLE when fetch_en = 0 and no redirect.
  - FETCH to MISALIGN on a misaligned redirect (only with the feature compiled in).
  - MISALIGN to FETCH only on an aligned redirect.
- Issue condition (combinational cntlr_rd): state == FETCH, fetch_en, !redirect_valid, outstanding + squash_cnt < MAX_OUT, and fifo_count + outstanding < FIFO_DEPTH.
  - On issue, req_pc += 4 and outstanding increments.
  - This credit rule guarantees every live response has a FIFO slot; no backpressure toward the controller exists.
- Responses:
  - If squash_cnt > 0, the response is dropped and squash_cnt decrements.
  - Otherwise push {resp_pc, cntlr_rd_data}, resp_pc += 4, outstanding decrements.
- Redirect (highest priority):
  - FIFO flushed; req_pc = resp_pc = redirect_pc.
  - squash_cnt += outstanding (including a response arriving the same cycle, which counts as old-stream and is dropped); outstanding = 0.
  - No issue that cycle; earliest new request is the next cycle.
- Latency: redirect to first cntlr_rd is 1 cycle. With a 1-cycle controller, first instr_valid comes 2 cycles after the request.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full (the credit rule prevents overflow) or empty (no bypass; the data appears next cycle).
  - instr_data/instr_pc are registered heads, stable while instr_valid && !instr_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic:
  - PC adds wrap mod 2^32.
  - cntlr_raddr wraps naturally at 2^ADDR_WIDTH words; upper PC bits are ignored.
- fetch_en = 0 stops issue only; in-flight responses still land and decode keeps draining.

Optional Feature:
Macro: IFU_ALIGN_CHK_EN
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misalign, flushes, squashes and enters MISALIGN (no issue).
  - The flag clears on the next aligned redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 0.
  - fetch_misalign is tied 0; MISALIGN is unreachable.

Decomposition:
- Shared package ifu_pkg:
  - RESET_PC default, PC_INC = 4.
  - State enum (IDLE, FETCH, MISALIGN).
  - Typedef fetch_entry_t {pc[31:0], instr[DATA_WIDTH-1:0]}.
- One sub-module: ifu_fifo, a synchronous FIFO with count output, parameterised on width and depth.

Test Plan:
- Reset release, fetch_en = 1, 1-cycle responder with mem[k] = 32'h1000_0000 + k, instr_ready = 1 → instr_pc 0, 4, 8, 12 with data 1000_0000..1000_0003, no gaps after fill.
- instr_ready = 0 for 20 cycles → exactly 4 entries held, cntlr_rd stays 0 after credits run out, no overflow; release → PCs 0..12 in order.
- 3-cycle responder, redirect to 32'h40 while 2 reads are in flight → both responses dropped, squash_cnt returns to 0, first instr_pc = 32'h40 with data mem[16].
- Redirect in the same cycle as cntlr_rd_valid → that response is dropped, next instr_pc = redirect target.
- fetch_en toggled 1→0 mid-stream → in-flight data still delivered, no new cntlr_rd; back to 1 → continues at the next PC.
- With IFU_ALIGN_CHK_EN: redirect to 32'h42 → fetch_misalign = 1, no requests; redirect to 32'h80 → flag clears and fetch resumes at 32'h80. Without the macro: 32'h42 fetches from 32'h40.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam int unsigned IFU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        MISALIGN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0]               pc;
        logic [IFU_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with occupancy count and synchronous flush.
module ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, credit-limited reads, prefetch FIFO.
// Optional macro IFU_ALIGN_CHK_EN enables misaligned-redirect detection (MISALIGN state).
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_OUT    = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  cntlr_rd,
    output logic [ADDR_WIDTH-1:0] cntlr_raddr,
    input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
    input  logic                  cntlr_rd_valid,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [31:0]           instr_pc,
    output logic                  fetch_misalign,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned EW = 32 + DATA_WIDTH;

    ifu_state_e       state_q, state_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [OW-1:0]    out_q, out_d;
    logic [OW-1:0]    squash_q, squash_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [EW-1:0]    fifo_rdata;

    logic [31:0]      redir_pc;
    logic             redir_misaligned;

`ifdef IFU_ALIGN_CHK_EN
    logic             misalign_q, misalign_d;
    assign redir_pc         = redirect_pc;
    assign redir_misaligned = |redirect_pc[1:0];
    assign fetch_misalign   = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = redir_misaligned;
        end
    end
`else
    assign redir_pc         = redirect_pc & ~32'h3;
    assign redir_misaligned = 1'b0;
    assign fetch_misalign   = 1'b0;
`endif

    // Credits cover both the read-port limit and guaranteed FIFO space for every live response.
    assign cntlr_rd = (state_q == FETCH) && fetch_en && !redirect_valid
                   && ((32'(out_q) + 32'(squash_q)) < MAX_OUT)
                   && ((32'(fifo_count) + 32'(out_q)) < FIFO_DEPTH);

    assign cntlr_raddr = req_pc_q[ADDR_WIDTH+1:2];
    assign instr_valid = !fifo_empty;
    assign instr_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign instr_pc    = fifo_rdata[DATA_WIDTH +: 32];
    assign fifo_pop    = instr_valid && instr_ready;
    assign busy        = (out_q != '0) || (squash_q != '0);

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        squash_d   = squash_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            req_pc_d   = redir_pc;
            resp_pc_d  = redir_pc;
            // A response landing this cycle belongs to the old stream: it retires one squash/outstanding slot.
            squash_d   = squash_q + out_q - OW'(cntlr_rd_valid);
            out_d      = '0;
            if (redir_misaligned) begin
                state_d = MISALIGN;
            end else if (state_q == IDLE && !fetch_en) begin
                state_d = IDLE;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                IDLE:    if (fetch_en)  state_d = FETCH;
                FETCH:   if (!fetch_en) state_d = IDLE;
                default: state_d = state_q;
            endcase

            if (cntlr_rd) begin
                req_pc_d = req_pc_q + PC_INC;
            end

            if (cntlr_rd_valid) begin
                if (squash_q != '0) begin
                    squash_d = squash_q - OW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + PC_INC;
                end
            end

            out_d = out_q + OW'(cntlr_rd) - OW'(fifo_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_pc_q  <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            squash_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            squash_q  <= squash_d;
        end
    end

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i ({resp_pc_q, cntlr_rd_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
